circular_shift_sequencer: RTL and testbench

CIRCULAR_SHIFT_SEQUENCER -- requirements
Module: circular_shift_sequencer

---
 rtl/circular_shift_sequencer.sv | 93 +++++++++
 tb/tb_circular_shift_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/circular_shift_sequencer.sv
// Multi-cycle barrel rotator: one log2 stage per BUSY cycle, ready/valid on both sides.
// A request is latched in IDLE, rotated over W cycles and held in DONE until taken.
module circular_shift_sequencer #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [N-1:0] up_data,
    input  logic [W-1:0] up_amt,
    input  logic         up_dir,
    output logic         down_valid,
    input  logic         down_ready,
    output logic [N-1:0] down_data
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [W-1:0] LAST_STAGE = W'(W - 1);

    state_t       state;
    logic [N-1:0] work_q;
    logic [N-1:0] down_data_q;
    logic [N-1:0] stage_next;
    logic [W-1:0] amt_q;
    logic [W-1:0] amt_shr;
    logic [W-1:0] stage_cnt;
    logic         dir_q;

    function automatic logic [N-1:0] rotate_by(input logic [N-1:0] d,
                                               input int unsigned sh,
                                               input logic right);
        if (right) begin
            return (d >> sh) | (d << (N - sh));
        end
        return (d << sh) | (d >> (N - sh));
    endfunction

    // Stage k rotates by 2^k only when bit k of the latched amount is set.
    always_comb begin
        amt_shr    = amt_q >> stage_cnt;
        stage_next = work_q;
        if (amt_shr[0]) begin
            stage_next = rotate_by(work_q, 32'd1 << stage_cnt, dir_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            stage_cnt   <= '0;
            work_q      <= '0;
            amt_q       <= '0;
            dir_q       <= 1'b0;
            down_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (up_valid) begin
                        work_q    <= up_data;
                        amt_q     <= up_amt;
                        dir_q     <= up_dir;
                        stage_cnt <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    work_q    <= stage_next;
                    stage_cnt <= stage_cnt + W'(1);
                    if (stage_cnt == LAST_STAGE) begin
                        down_data_q <= stage_next;
                        stage_cnt   <= '0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (down_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags are gated by rst so nothing is offered or accepted during reset.
    assign up_ready   = (state == IDLE) && !rst;
    assign down_valid = (state == DONE) && !rst;
    assign down_data  = down_data_q;

endmodule

// File: tb/tb_circular_shift_sequencer.sv
// Scoreboard bench for circular_shift_sequencer: directed vectors, back-pressure,
// mid-operation reset, streaming and randomized transactions against a rotation model.
`timescale 1ns/1ps
module tb_circular_shift_sequencer;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         up_valid;
    logic         up_ready;
    logic [N-1:0] up_data;
    logic [W-1:0] up_amt;
    logic         up_dir;
    logic         down_valid;
    logic         down_ready;
    logic [N-1:0] down_data;

    circular_shift_sequencer #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_amt     (up_amt),
        .up_dir     (up_dir),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           n_acc = 0;
    int           n_done = 0;
    int           done_cyc = 0;
    bit           in_flight = 1'b0;
    bit           exp_vld = 1'b0;
    bit           after_rst = 1'b0;
    logic [N-1:0] next_exp;
    logic [N-1:0] sb[$];
    int           acc_times[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Rotation by repeated single-position moves.
    function automatic logic [N-1:0] ref_rot(input logic [N-1:0] d, input int amt, input logic right);
        logic [N-1:0] r;
        r = d;
        for (int i = 0; i < amt % N; i++) begin
            r = right ? {r[0], r[N-1:1]} : {r[N-2:0], r[N-1]};
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout want handshake at %0t", nm, $time);
    endtask

    // Monitor: tracks the transaction the model expects and checks the DUT each cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_up_ready", up_ready, 32'd0);
            chk("rst_down_valid", down_valid, 32'd0);
            sb.delete();
            in_flight = 1'b0;
            exp_vld   = 1'b0;
            after_rst = 1'b1;
        end else begin
            exp_vld = in_flight && (cyc >= done_cyc);
            chk("up_ready", up_ready, !in_flight);
            chk("down_valid", down_valid, exp_vld);
            if (after_rst) begin
                chk("post_rst_down_data", down_data, 32'd0);
                after_rst = 1'b0;
            end
            if (exp_vld) begin
                if (sb.size() == 0) begin
                    tmo("scoreboard_empty");
                end else begin
                    chk("down_data", down_data, sb[0]);
                    if (down_ready) begin
                        void'(sb.pop_front());
                        in_flight = 1'b0;
                        n_done++;
                    end
                end
            end else if (!in_flight && up_valid) begin
                sb.push_back(next_exp);
                in_flight = 1'b1;
                done_cyc  = cyc + 1 + W;
                acc_times.push_back(cyc + 1);
                n_acc++;
            end
        end
    end

    task automatic run_txn(input logic [N-1:0] d, input logic [W-1:0] a, input logic dr,
                           input logic [N-1:0] exp, input int stall, input bit noisy);
        int a0;
        int d0;
        int k;
        next_exp   = exp;
        up_data    = d;
        up_amt     = a;
        up_dir     = dr;
        up_valid   = 1'b1;
        down_ready = (stall == 0);
        a0 = n_acc;
        d0 = n_done;
        k = 0;
        while (n_acc == a0 && k < 40) begin
            @(posedge clk); #2;
            k++;
        end
        if (n_acc == a0) begin
            tmo("accept");
            up_valid   = 1'b0;
            down_ready = 1'b1;
            return;
        end
        // Inputs change while busy; the DUT must not pick any of them up.
        up_valid = noisy;
        up_data  = N'($urandom);
        up_amt   = W'($urandom);
        up_dir   = 1'($urandom);
        next_exp = N'($urandom);
        if (stall > 0) begin
            k = 0;
            while (!exp_vld && k < 40) begin
                @(posedge clk); #2;
                k++;
            end
            if (!exp_vld) tmo("result_valid");
            repeat (stall) @(posedge clk);
            #2;
            down_ready = 1'b1;
            up_valid   = 1'b0;
        end
        k = 0;
        while (n_done == d0 && k < 40) begin
            @(posedge clk); #2;
            k++;
        end
        if (n_done == d0) tmo("handoff");
        up_valid = 1'b0;
    endtask

    initial begin
        int a0;
        int d0;
        int k;
        logic [N-1:0] sd;
        logic [W-1:0] sa;
        logic         sr;

        rst        = 1'b1;
        up_valid   = 1'b0;
        up_data    = '0;
        up_amt     = '0;
        up_dir     = 1'b0;
        down_ready = 1'b0;
        next_exp   = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;

        run_txn(8'b10110101, 3'd3, 1'b1, 8'b10110110, 0, 1'b0);
        run_txn(8'b10110101, 3'd3, 1'b0, 8'b10101101, 0, 1'b0);
        run_txn(8'b00100110, 3'd3, 1'b1, 8'b11000100, 2, 1'b0);
        run_txn(8'b01100110, 3'd0, 1'b0, 8'b01100110, 0, 1'b0);
        run_txn(8'b01100110, 3'd0, 1'b1, 8'b01100110, 1, 1'b0);
        run_txn(8'b01100110, 3'd7, 1'b0, 8'b00110011, 0, 1'b0);
        run_txn(8'b10110101, 3'd5, 1'b1, ref_rot(8'b10110101, 5, 1'b1), 5, 1'b1);

        // Abort a transaction with a one-cycle reset while at stage 1.
        next_exp   = ref_rot(8'hC3, 2, 1'b0);
        up_data    = 8'hC3;
        up_amt     = 3'd2;
        up_dir     = 1'b0;
        up_valid   = 1'b1;
        down_ready = 1'b1;
        a0 = n_acc;
        k = 0;
        while (n_acc == a0 && k < 40) begin
            @(posedge clk); #2;
            k++;
        end
        if (n_acc == a0) tmo("accept_before_reset");
        up_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        run_txn(8'h5A, 3'd1, 1'b0, 8'hB4, 0, 1'b0);

        // Streaming: four back-to-back requests with both handshakes held high.
        acc_times.delete();
        down_ready = 1'b1;
        d0 = n_done;
        for (int i = 0; i < 4; i++) begin
            sd = N'($urandom);
            sa = W'($urandom);
            sr = 1'($urandom);
            up_data  = sd;
            up_amt   = sa;
            up_dir   = sr;
            next_exp = ref_rot(sd, int'(sa), sr);
            up_valid = 1'b1;
            a0 = n_acc;
            k = 0;
            while (n_acc == a0 && k < 40) begin
                @(posedge clk); #2;
                k++;
            end
            if (n_acc == a0) tmo("stream_accept");
        end
        up_valid = 1'b0;
        k = 0;
        while (n_done < d0 + 4 && k < 60) begin
            @(posedge clk); #2;
            k++;
        end
        if (n_done < d0 + 4) tmo("stream_done");
        chk("stream_accepts", acc_times.size(), 32'd4);
        for (int i = 1; i < acc_times.size(); i++) begin
            chk("stream_spacing", acc_times[i] - acc_times[i-1], W + 2);
        end

        for (int i = 0; i < 25; i++) begin
            sd = N'($urandom);
            sa = W'($urandom);
            sr = 1'($urandom);
            run_txn(sd, sa, sr, ref_rot(sd, int'(sa), sr), int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
